// File: rtl/usb_fs_out_ep_reader_pkg.sv
// Shared constants for the USB full-speed OUT endpoint reader and its FIFO.
package usb_fs_out_ep_reader_pkg;

  // Width of one byte lane between the protocol engine and the application.
  localparam int BYTE_W = 8;

  // Cycles between a get to the PE buffer and the byte showing up on out_ep_data.
  localparam int PE_READ_LAT = 1;

endpackage

// File: rtl/usb_fs_out_ep_reader_if.sv
// Bus between one OUT endpoint reader and the OUT arbiter / protocol engine buffer.
interface usb_fs_out_ep_reader_if;
  import usb_fs_out_ep_reader_pkg::*;

  logic              out_ep_req;
  logic              out_ep_grant;
  logic              out_ep_data_avail;
  logic              out_ep_setup;
  logic              out_ep_data_get;
  logic [BYTE_W-1:0] out_ep_data;
  logic              out_ep_stall;

  // Endpoint reader side.
  modport master (
    output out_ep_req,
    output out_ep_data_get,
    output out_ep_stall,
    input  out_ep_grant,
    input  out_ep_data_avail,
    input  out_ep_setup,
    input  out_ep_data
  );

  // Arbiter / protocol engine side.
  modport slave (
    input  out_ep_req,
    input  out_ep_data_get,
    input  out_ep_stall,
    output out_ep_grant,
    output out_ep_data_avail,
    output out_ep_setup,
    output out_ep_data
  );

endinterface

// File: rtl/usb_fs_sync_fifo.sv
// Single-clock FIFO with occupancy output; shared by the OUT and IN endpoint paths.
// Writes on full and reads on empty are ignored. Head entry is visible combinationally.
module usb_fs_sync_fifo #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because empty hides stale entries.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/usb_fs_out_ep_reader.sv
// Per-endpoint OUT client: arbitrates for the PE buffer, drains bytes into a local
// FIFO and presents them to the application as a valid/ready stream with a SETUP tag.
module usb_fs_out_ep_reader
  import usb_fs_out_ep_reader_pkg::*;
#(
  parameter  int FIFO_DEPTH = 16,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  usb_fs_out_ep_reader_if.master  ep,
  input  logic                    app_stall,
  output logic [BYTE_W-1:0]       app_data,
  output logic                    app_setup,
  output logic                    app_valid,
  input  logic                    app_ready,
  output logic [AW:0]             fifo_level
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } state_t;

  localparam int CW = AW + 2;

  state_t                 state;
  state_t                 state_next;
  logic [PE_READ_LAT-1:0] get_pipe;
  logic [PE_READ_LAT-1:0] setup_pipe;
  logic                   inflight;
  logic                   inflight_setup;
  logic [CW-1:0]          committed;
  logic                   space_ok;
  logic                   get;
  logic [BYTE_W:0]        fifo_head;
  logic                   fifo_empty;
  logic                   fifo_full;

  // Bytes already stored plus bytes requested but not yet returned by the PE.
  assign committed = CW'(fifo_level) + CW'($countones(get_pipe));
  assign space_ok  = !fifo_full && (committed < CW'(FIFO_DEPTH));

  assign inflight       = get_pipe[PE_READ_LAT-1];
  assign inflight_setup = setup_pipe[PE_READ_LAT-1];

  assign get                = (state == DRAIN) && ep.out_ep_grant && ep.out_ep_data_avail && space_ok;
  assign ep.out_ep_data_get = get;
  assign ep.out_ep_req      = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: hold the request through grant loss and full FIFO; leave only when drained.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ep.out_ep_data_avail && space_ok) state_next = REQ;
      REQ:     if (ep.out_ep_grant) state_next = DRAIN;
      DRAIN:   if (!ep.out_ep_data_avail && (get_pipe == '0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Track gets through the PE read latency, carrying the SETUP tag seen at get time.
  always_ff @(posedge clk) begin
    if (reset) begin
      get_pipe   <= '0;
      setup_pipe <= '0;
    end else begin
      get_pipe[0]   <= get;
      setup_pipe[0] <= ep.out_ep_setup;
      for (int i = 1; i < PE_READ_LAT; i++) begin
        get_pipe[i]   <= get_pipe[i-1];
        setup_pipe[i] <= setup_pipe[i-1];
      end
    end
  end

  // Stall is a plain one-cycle registered copy, independent of the drain logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      ep.out_ep_stall <= 1'b0;
    end else begin
      ep.out_ep_stall <= app_stall;
    end
  end

  usb_fs_sync_fifo #(
    .WIDTH (BYTE_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (inflight),
    .wr_data ({inflight_setup, ep.out_ep_data}),
    .rd_en   (app_ready),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  // Head is forced to zero while empty so stale storage never reaches the application.
  assign app_valid = !fifo_empty;
  assign app_data  = app_valid ? fifo_head[BYTE_W-1:0] : '0;
  assign app_setup = app_valid ? fifo_head[BYTE_W] : 1'b0;

endmodule

// File: tb/tb_usb_fs_out_ep_reader.sv
// Directed bench for usb_fs_out_ep_reader: one default-depth instance and one depth-4
// instance, each fed by a small PE buffer model; the arbiter grant is driven directly.
module tb_usb_fs_out_ep_reader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic grant = 1'b0;
  logic setup = 1'b0;
  logic app_ready = 1'b0;
  logic app_stall = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  usb_fs_out_ep_reader_if bus0 ();
  usb_fs_out_ep_reader_if bus1 ();

  logic [7:0] app_data0, app_data1;
  logic       app_setup0, app_setup1;
  logic       app_valid0, app_valid1;
  logic [4:0] fifo_level0;
  logic [2:0] fifo_level1;

  usb_fs_out_ep_reader u_dut16 (
    .clk        (clk),
    .reset      (reset),
    .ep         (bus0),
    .app_stall  (app_stall),
    .app_data   (app_data0),
    .app_setup  (app_setup0),
    .app_valid  (app_valid0),
    .app_ready  (app_ready),
    .fifo_level (fifo_level0)
  );

  usb_fs_out_ep_reader #(.FIFO_DEPTH(4)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .ep         (bus1),
    .app_stall  (app_stall),
    .app_data   (app_data1),
    .app_setup  (app_setup1),
    .app_valid  (app_valid1),
    .app_ready  (app_ready),
    .fifo_level (fifo_level1)
  );

  // PE buffer models: byte array, fill count and read index; data returns one clk after get.
  logic [7:0] pe_buf0 [16];
  logic [7:0] pe_buf1 [16];
  int         pe_cnt0 = 0, pe_cnt1 = 0;
  int         pe_idx0 = 0, pe_idx1 = 0;
  logic       pe_clr0 = 1'b0, pe_clr1 = 1'b0;
  logic [7:0] pe_q0 = 8'h00, pe_q1 = 8'h00;

  assign bus0.out_ep_grant      = grant;
  assign bus0.out_ep_setup      = setup;
  assign bus0.out_ep_data_avail = (pe_idx0 < pe_cnt0);
  assign bus0.out_ep_data       = pe_q0;
  assign bus1.out_ep_grant      = grant;
  assign bus1.out_ep_setup      = setup;
  assign bus1.out_ep_data_avail = (pe_idx1 < pe_cnt1);
  assign bus1.out_ep_data       = pe_q1;

  // PE read port for the default-depth instance.
  always @(posedge clk) begin
    if (pe_clr0) pe_idx0 <= 0;
    else if (bus0.out_ep_data_get) begin
      pe_q0   <= pe_buf0[pe_idx0];
      pe_idx0 <= pe_idx0 + 1;
    end
  end

  // PE read port for the depth-4 instance.
  always @(posedge clk) begin
    if (pe_clr1) pe_idx1 <= 0;
    else if (bus1.out_ep_data_get) begin
      pe_q1   <= pe_buf1[pe_idx1];
      pe_idx1 <= pe_idx1 + 1;
    end
  end

  // Record every get and every byte the application accepts, away from the clock edge.
  logic [8:0] got0 [$];
  logic [8:0] got1 [$];
  int         gets0 = 0, gets1 = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus0.out_ep_data_get) gets0 <= gets0 + 1;
      if (bus1.out_ep_data_get) gets1 <= gets1 + 1;
      if (app_valid0 && app_ready) got0.push_back({app_setup0, app_data0});
      if (app_valid1 && app_ready) got1.push_back({app_setup1, app_data1});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_pe();
    pe_cnt0 = 0;
    pe_cnt1 = 0;
    pe_clr0 = 1'b1;
    pe_clr1 = 1'b1;
    @(posedge clk); #1;
    pe_clr0 = 1'b0;
    pe_clr1 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (bus0.out_ep_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_req got %b want 0", bus0.out_ep_req); end
    tests++; if (bus0.out_ep_data_get !== 1'b0) begin fails++; $display("[TB] FAIL reset_get got %b want 0", bus0.out_ep_data_get); end
    tests++; if (bus0.out_ep_stall !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall got %b want 0", bus0.out_ep_stall); end
    tests++; if (app_valid0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got %b want 0", app_valid0); end
    tests++; if (app_data0 !== 8'h00) begin fails++; $display("[TB] FAIL reset_data got %h want 00", app_data0); end
    tests++; if (app_setup0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_setup got %b want 0", app_setup0); end
    tests++; if (fifo_level0 !== 5'd0) begin fails++; $display("[TB] FAIL reset_level got %0d want 0", fifo_level0); end
    tests++; if (fifo_level1 !== 3'd0) begin fails++; $display("[TB] FAIL reset_level4 got %0d want 0", fifo_level1); end
    tests++; if (bus1.out_ep_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_req4 got %b want 0", bus1.out_ep_req); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic       exp_req [9];
    logic       exp_get [9];
    logic       exp_val [9];
    logic [7:0] exp_dat [9];
    logic [4:0] exp_lvl [9];
    exp_req = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    exp_get = '{0, 0, 1, 1, 1, 1, 0, 0, 0};
    exp_val = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    exp_dat = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    exp_lvl = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    clear_pe();
    setup = 1'b0; grant = 1'b1; app_ready = 1'b1;
    pe_buf0[0] = 8'h11; pe_buf0[1] = 8'h22; pe_buf0[2] = 8'h33; pe_buf0[3] = 8'h44;
    pe_cnt0 = 4;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      tests++; if (bus0.out_ep_req !== exp_req[c]) begin fails++; $display("[TB] FAIL basic_req c%0d got %b want %b", c, bus0.out_ep_req, exp_req[c]); end
      tests++; if (bus0.out_ep_data_get !== exp_get[c]) begin fails++; $display("[TB] FAIL basic_get c%0d got %b want %b", c, bus0.out_ep_data_get, exp_get[c]); end
      tests++; if (app_valid0 !== exp_val[c]) begin fails++; $display("[TB] FAIL basic_valid c%0d got %b want %b", c, app_valid0, exp_val[c]); end
      tests++; if (app_data0 !== exp_dat[c] || app_setup0 !== 1'b0) begin fails++; $display("[TB] FAIL basic_data c%0d got %b/%h want 0/%h", c, app_setup0, app_data0, exp_dat[c]); end
      tests++; if (fifo_level0 !== exp_lvl[c]) begin fails++; $display("[TB] FAIL basic_level c%0d got %0d want %0d", c, fifo_level0, exp_lvl[c]); end
    end
  endtask

  task automatic test_setup();
    logic [7:0] bytes [8];
    logic [8:0] obs;
    int         s;
    int         c;
    bytes = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
    clear_pe();
    setup = 1'b1; grant = 1'b1; app_ready = 1'b1;
    s = got0.size();
    for (int i = 0; i < 8; i++) pe_buf0[i] = bytes[i];
    pe_cnt0 = 8;
    for (c = 0; c < 60; c++) begin
      @(negedge clk);
      if ((got0.size() - s) >= 8 && !bus0.out_ep_req) break;
    end
    tests++; if (c >= 60) begin fails++; $display("[TB] FAIL setup_done got %0d bytes want 8", got0.size() - s); end
    for (int i = 0; i < 8; i++) begin
      obs = (s + i < got0.size()) ? got0[s+i] : 9'h1ff;
      tests++; if (obs !== {1'b1, bytes[i]}) begin fails++; $display("[TB] FAIL setup_byte%0d got %h want %h", i, obs, {1'b1, bytes[i]}); end
    end
    @(posedge clk); #1;
    setup = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [8:0] obs;
    int         s;
    int         g;
    int         c;
    clear_pe();
    setup = 1'b0; grant = 1'b1; app_ready = 1'b0;
    s = got1.size();
    g = gets1;
    for (int i = 0; i < 6; i++) pe_buf1[i] = 8'hA1 + 8'(i);
    pe_cnt1 = 6;
    repeat (20) @(negedge clk);
    tests++; if (gets1 - g !== 4) begin fails++; $display("[TB] FAIL full_gets got %0d want 4", gets1 - g); end
    tests++; if (fifo_level1 !== 3'd4) begin fails++; $display("[TB] FAIL full_level got %0d want 4", fifo_level1); end
    tests++; if (bus1.out_ep_req !== 1'b1) begin fails++; $display("[TB] FAIL full_req got %b want 1", bus1.out_ep_req); end
    tests++; if (bus1.out_ep_data_get !== 1'b0) begin fails++; $display("[TB] FAIL full_get got %b want 0", bus1.out_ep_data_get); end
    tests++; if (app_valid1 !== 1'b1 || app_data1 !== 8'hA1) begin fails++; $display("[TB] FAIL full_head got %b/%h want 1/a1", app_valid1, app_data1); end
    @(posedge clk); #1;
    app_ready = 1'b1;
    for (c = 0; c < 60; c++) begin
      @(negedge clk);
      if ((got1.size() - s) >= 6 && !bus1.out_ep_req) break;
    end
    tests++; if (c >= 60) begin fails++; $display("[TB] FAIL full_done got %0d bytes want 6", got1.size() - s); end
    tests++; if (gets1 - g !== 6) begin fails++; $display("[TB] FAIL full_total_gets got %0d want 6", gets1 - g); end
    tests++; if (got1.size() - s !== 6) begin fails++; $display("[TB] FAIL full_count got %0d want 6", got1.size() - s); end
    for (int i = 0; i < 6; i++) begin
      obs = (s + i < got1.size()) ? got1[s+i] : 9'h1ff;
      tests++; if (obs !== {1'b0, 8'hA1 + 8'(i)}) begin fails++; $display("[TB] FAIL full_byte%0d got %h want %h", i, obs, {1'b0, 8'hA1 + 8'(i)}); end
    end
  endtask

  task automatic test_grant_loss();
    logic [8:0] obs;
    int         s;
    int         g;
    int         n;
    int         c;
    clear_pe();
    setup = 1'b0; grant = 1'b1; app_ready = 1'b1;
    s = got0.size();
    g = gets0;
    for (int i = 0; i < 5; i++) pe_buf0[i] = 8'h51 + 8'(i);
    pe_cnt0 = 5;
    n = 0;
    for (c = 0; c < 30 && n < 2; c++) begin
      @(negedge clk);
      if (bus0.out_ep_data_get) n++;
    end
    tests++; if (n != 2) begin fails++; $display("[TB] FAIL gl_first_gets got %0d want 2", n); end
    @(posedge clk); #1;
    grant = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++; if (bus0.out_ep_data_get !== 1'b0) begin fails++; $display("[TB] FAIL gl_get_ungranted c%0d got %b want 0", k, bus0.out_ep_data_get); end
      tests++; if (bus0.out_ep_req !== 1'b1) begin fails++; $display("[TB] FAIL gl_req_held c%0d got %b want 1", k, bus0.out_ep_req); end
    end
    tests++; if (got0.size() - s !== 2) begin fails++; $display("[TB] FAIL gl_inflight_captured got %0d bytes want 2", got0.size() - s); end
    @(posedge clk); #1;
    grant = 1'b1;
    @(negedge clk);
    tests++; if (bus0.out_ep_data_get !== 1'b1) begin fails++; $display("[TB] FAIL gl_resume got %b want 1", bus0.out_ep_data_get); end
    for (c = 0; c < 60; c++) begin
      @(negedge clk);
      if ((got0.size() - s) >= 5 && !bus0.out_ep_req) break;
    end
    tests++; if (c >= 60) begin fails++; $display("[TB] FAIL gl_done got %0d bytes want 5", got0.size() - s); end
    tests++; if (gets0 - g !== 5) begin fails++; $display("[TB] FAIL gl_total_gets got %0d want 5", gets0 - g); end
    tests++; if (got0.size() - s !== 5) begin fails++; $display("[TB] FAIL gl_count got %0d want 5", got0.size() - s); end
    for (int i = 0; i < 5; i++) begin
      obs = (s + i < got0.size()) ? got0[s+i] : 9'h1ff;
      tests++; if (obs !== {1'b0, 8'h51 + 8'(i)}) begin fails++; $display("[TB] FAIL gl_byte%0d got %h want %h", i, obs, {1'b0, 8'h51 + 8'(i)}); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int c;
    clear_pe();
    setup = 1'b0; grant = 1'b1; app_ready = 1'b0;
    for (int i = 0; i < 6; i++) pe_buf0[i] = 8'h61 + 8'(i);
    pe_cnt0 = 6;
    n = 0;
    for (c = 0; c < 30 && n < 3; c++) begin
      @(negedge clk);
      if (bus0.out_ep_data_get) n++;
    end
    tests++; if (n != 3) begin fails++; $display("[TB] FAIL rm_gets_before got %0d want 3", n); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests++; if (bus0.out_ep_req !== 1'b0) begin fails++; $display("[TB] FAIL rm_req got %b want 0", bus0.out_ep_req); end
    tests++; if (bus0.out_ep_data_get !== 1'b0) begin fails++; $display("[TB] FAIL rm_get got %b want 0", bus0.out_ep_data_get); end
    tests++; if (app_valid0 !== 1'b0) begin fails++; $display("[TB] FAIL rm_valid got %b want 0", app_valid0); end
    tests++; if (fifo_level0 !== 5'd0) begin fails++; $display("[TB] FAIL rm_level got %0d want 0", fifo_level0); end
    @(negedge clk);
    tests++; if (fifo_level0 !== 5'd0) begin fails++; $display("[TB] FAIL rm_inflight_dropped level got %0d want 0", fifo_level0); end
    @(posedge clk); #1;
    app_ready = 1'b1;
    for (c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!bus0.out_ep_data_avail && !bus0.out_ep_req && !app_valid0) break;
    end
    tests++; if (c >= 60) begin fails++; $display("[TB] FAIL rm_recover got req %b want 0", bus0.out_ep_req); end
  endtask

  task automatic test_stall();
    @(posedge clk); #1;
    app_stall = 1'b1;
    @(negedge clk);
    tests++; if (bus0.out_ep_stall !== 1'b0) begin fails++; $display("[TB] FAIL stall_early got %b want 0", bus0.out_ep_stall); end
    @(posedge clk); #1;
    app_stall = 1'b0;
    @(negedge clk);
    tests++; if (bus0.out_ep_stall !== 1'b1) begin fails++; $display("[TB] FAIL stall_high got %b want 1", bus0.out_ep_stall); end
    tests++; if (bus1.out_ep_stall !== 1'b1) begin fails++; $display("[TB] FAIL stall_high4 got %b want 1", bus1.out_ep_stall); end
    tests++; if (bus0.out_ep_req !== 1'b0 || app_valid0 !== 1'b0) begin fails++; $display("[TB] FAIL stall_datapath got req %b valid %b want 0 0", bus0.out_ep_req, app_valid0); end
    @(negedge clk);
    tests++; if (bus0.out_ep_stall !== 1'b0) begin fails++; $display("[TB] FAIL stall_low got %b want 0", bus0.out_ep_stall); end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_basic();
    test_setup();
    test_fifo_full();
    test_grant_loss();
    test_reset_mid();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
